// File: rtl/operand_frame_collector.sv
// operand_frame_collector: assembles NUM_OPS operands plus one opcode word into a frame
// and presents it downstream through a valid/ack handshake, parking one extra frame.
//   clk, reset (async, active-low)
//   in / i_ready / i_accept    : serial word input, one word per cycle
//   frame_abort                : drop the partially assembled frame
//   clr_err / o_overrun        : sticky flag for words offered while i_accept=0
//   num_bus / op_code / o_ready / o_ack : registered frame output and handshake
module operand_frame_collector #(
    parameter int DATA_W   = 8,
    parameter int NUM_OPS  = 2,
    parameter int OP_BYTES = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_W-1:0]                   in,
    input  logic                                i_ready,
    output logic                                i_accept,
    input  logic                                frame_abort,
    input  logic                                clr_err,
    output logic [NUM_OPS*OP_BYTES*DATA_W-1:0]  num_bus,
    output logic [DATA_W-1:0]                   op_code,
    output logic                                o_ready,
    input  logic                                o_ack,
    output logic                                o_overrun
);
    localparam int NW    = NUM_OPS * OP_BYTES;
    localparam int TOTAL = NW + 1;
    localparam int CW    = $clog2(TOTAL);
    localparam int NB    = NW * DATA_W;

    typedef enum logic {COLLECT, PARKED} state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TOTAL*DATA_W-1:0]   asm_q;
    logic [NB-1:0]             num_bus_q;
    logic [DATA_W-1:0]         op_code_q;
    logic                      o_ready_q, o_overrun_q;
    logic                      take, last, present;

    always_comb begin
        take    = i_ready & (state_q == COLLECT) & ~frame_abort;
        last    = take & (cnt_q == CW'(TOTAL - 1));
        // A completing word goes straight to the outputs unless a frame is still unacknowledged
        present = last & (~o_ready_q | o_ack);
        cnt_d   = ((frame_abort & (state_q == COLLECT)) | last) ? '0 : cnt_q + CW'(take);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            asm_q       <= '0;
            num_bus_q   <= '0;
            op_code_q   <= '0;
            o_ready_q   <= 1'b0;
            o_overrun_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            o_overrun_q <= (i_ready & (state_q == PARKED)) | (o_overrun_q & ~clr_err);
            if (take)
                asm_q[cnt_q*DATA_W +: DATA_W] <= in;
            if (present) begin
                num_bus_q <= asm_q[NB-1:0];
                op_code_q <= in;
                o_ready_q <= 1'b1;
            end else if (last) begin
                state_q <= PARKED;
            end else if (state_q == PARKED && o_ack) begin
                // Parked frame moves to the outputs; o_ready stays high
                num_bus_q <= asm_q[NB-1:0];
                op_code_q <= asm_q[TOTAL*DATA_W-1 -: DATA_W];
                state_q   <= COLLECT;
            end else if (o_ack) begin
                o_ready_q <= 1'b0;
            end
        end
    end

    assign i_accept  = (state_q == COLLECT);
    assign num_bus   = num_bus_q;
    assign op_code   = op_code_q;
    assign o_ready   = o_ready_q;
    assign o_overrun = o_overrun_q;
endmodule

// File: tb/tb_operand_frame_collector.sv
// tb_operand_frame_collector: directed checks of operand_frame_collector (default and OP_BYTES=2)
module tb_operand_frame_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  din = '0;
    logic        i_ready = 1'b0, i_ready2 = 1'b0;
    logic        frame_abort = 1'b0, clr_err = 1'b0, o_ack = 1'b0;
    logic        acc0, rdy0, ovr0, acc1, rdy1, ovr1;
    logic [15:0] num0;
    logic [31:0] num1;
    logic [7:0]  op0, op1;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    operand_frame_collector u0 (
        .clk(clk), .reset(reset), .in(din), .i_ready(i_ready), .i_accept(acc0),
        .frame_abort(frame_abort), .clr_err(clr_err), .num_bus(num0), .op_code(op0),
        .o_ready(rdy0), .o_ack(o_ack), .o_overrun(ovr0)
    );

    operand_frame_collector #(.OP_BYTES(2)) u1 (
        .clk(clk), .reset(reset), .in(din), .i_ready(i_ready2), .i_accept(acc1),
        .frame_abort(frame_abort), .clr_err(clr_err), .num_bus(num1), .op_code(op1),
        .o_ready(rdy1), .o_ack(o_ack), .o_overrun(ovr1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] w, input bit second);
        din = w;
        if (second) i_ready2 = 1'b1; else i_ready = 1'b1;
        tick();
        i_ready  = 1'b0;
        i_ready2 = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        #3;
        chk("rst_num", num0, 0);
        chk("rst_op", op0, 0);
        chk("rst_rdy", rdy0, 0);
        chk("rst_ovr", ovr0, 0);
        chk("rst_acc", acc0, 1);
        chk("rst_num1", num1, 0);
        tick();
        reset = 1'b1;

        // T1
        o_ack = 1'b1;
        put(8'h12, 0); put(8'h34, 0);
        chk("t1_notyet", rdy0, 0);
        put(8'h05, 0);
        chk("t1_rdy", rdy0, 1);
        chk("t1_num", num0, 16'h3412);
        chk("t1_op", op0, 8'h05);
        tick();
        chk("t1_drop", rdy0, 0);
        chk("t1_hold", num0, 16'h3412);
        o_ack = 1'b0;

        // T2
        o_ack = 1'b1;
        put(8'h34, 1); put(8'h12, 1); put(8'h78, 1); put(8'h56, 1);
        chk("t2_notyet", rdy1, 0);
        put(8'h0A, 1);
        chk("t2_rdy", rdy1, 1);
        chk("t2_num", num1, 32'h5678_1234);
        chk("t2_op", op1, 8'h0A);
        tick();
        chk("t2_drop", rdy1, 0);
        o_ack = 1'b0;

        // T3
        put(8'h01, 0); put(8'h02, 0); put(8'h03, 0);
        chk("t3_rdy", rdy0, 1);
        chk("t3_num", num0, 16'h0201);
        put(8'h04, 0); put(8'h05, 0);
        chk("t3_acc_mid", acc0, 1);
        put(8'h06, 0);
        chk("t3_parked", acc0, 0);
        chk("t3_num_held", num0, 16'h0201);
        put(8'h07, 0);
        chk("t3_ovr", ovr0, 1);
        chk("t3_num_ovr", num0, 16'h0201);
        chk("t3_op_ovr", op0, 8'h03);
        o_ack = 1'b1;
        tick();
        chk("t3_unpark_num", num0, 16'h0504);
        chk("t3_unpark_op", op0, 8'h06);
        chk("t3_unpark_rdy", rdy0, 1);
        chk("t3_unpark_acc", acc0, 1);
        tick();
        chk("t3_drop", rdy0, 0);
        o_ack = 1'b0;
        chk("t3_ovr_sticky", ovr0, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr", ovr0, 0);

        // T4
        put(8'hAA, 0); put(8'hBB, 0);
        frame_abort = 1'b1; din = 8'hCC; i_ready = 1'b1;
        tick();
        frame_abort = 1'b0; i_ready = 1'b0;
        chk("t4_abort_ovr", ovr0, 0);
        put(8'h11, 0);
        chk("t4_no_stale", rdy0, 0);
        put(8'h22, 0);
        chk("t4_no_early", rdy0, 0);
        put(8'h33, 0);
        chk("t4_rdy", rdy0, 1);
        chk("t4_num", num0, 16'h2211);
        chk("t4_op", op0, 8'h33);
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        chk("t4_drop", rdy0, 0);

        // T5
        put(8'h01, 0); put(8'h02, 0); put(8'h03, 0);
        chk("t5_pre_rdy", rdy0, 1);
        put(8'h99, 0);
        reset = 1'b0;
        #1;
        chk("t5_rst_num", num0, 0);
        chk("t5_rst_op", op0, 0);
        chk("t5_rst_rdy", rdy0, 0);
        chk("t5_rst_acc", acc0, 1);
        #1;
        reset = 1'b1;
        put(8'h44, 0); put(8'h55, 0);
        chk("t5_no_early", rdy0, 0);
        put(8'h66, 0);
        chk("t5_rdy", rdy0, 1);
        chk("t5_num", num0, 16'h5544);
        chk("t5_op", op0, 8'h66);
        o_ack = 1'b1;
        tick();
        o_ack = 1'b0;
        chk("t5_drop", rdy0, 0);

        // T6
        for (int f = 0; f < 3; f++) begin
            b = 8'h21 + 8'(f * 16);
            put(b, 0);
            put(b + 8'd1, 0);
            if (f > 0) chk("t6_gapless", rdy0, 1);
            o_ack = 1'b1;
            put(b + 8'd2, 0);
            o_ack = 1'b0;
            chk("t6_rdy", rdy0, 1);
            chk("t6_num", num0, {b + 8'd1, b});
            chk("t6_op", op0, b + 8'd2);
        end
        chk("t6_ovr", ovr0, 0);
        chk("t6_acc", acc0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
